// File: rtl/program_memory_pkg.sv
// Shared definitions for the BIP program store: state codes,
// the halt opcode and the opcode field extractor.
package program_memory_pkg;

  localparam int NB_INSTRUC_P = 16;
  localparam int NB_OPCODE_P  = 5;

  localparam logic [NB_OPCODE_P-1:0] HLT_OPCODE = 5'b00000;

  typedef logic [2:0] state_t;

  localparam state_t IDLE  = 3'd0;
  localparam state_t LOAD  = 3'd1;
  localparam state_t READY = 3'd2;
  localparam state_t RUN   = 3'd3;
  localparam state_t HALT  = 3'd4;

  function automatic logic [NB_OPCODE_P-1:0] opcode_of(
    input logic [NB_INSTRUC_P-1:0] instr
  );
    return instr[NB_INSTRUC_P-1 -: NB_OPCODE_P];
  endfunction

endpackage

// File: rtl/program_memory_ram.sv
// Program word store: synchronous write for loading,
// registered read for fetch. Out-of-range reads return 0.
module prog_ram #(
  parameter int NB_DATA = 16,
  parameter int NB_ADDR = 11,
  parameter int DEPTH   = 2048
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic               re,
  input  logic [NB_ADDR-1:0] addr,
  input  logic [NB_DATA-1:0] wdata,
  output logic [NB_DATA-1:0] rdata
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [NB_DATA-1:0] mem [DEPTH];
  logic               in_range;

  assign in_range = {1'b0, addr} < (NB_ADDR+1)'(DEPTH);

  always_ff @(posedge clk) begin
    if (we && in_range)
      mem[addr[AW-1:0]] <= wdata;
  end

  // Contents survive reset; only the read register clears.
  always_ff @(posedge clk) begin
    if (rst)
      rdata <= '0;
    else if (re)
      rdata <= in_range ? mem[addr[AW-1:0]] : '0;
  end

endmodule

// File: rtl/program_memory.sv
// Program store for the accumulator CPU: stream load,
// run gating, one-cycle fetch, halt detect and cycle count.
module program_memory #(
  parameter int NB_INSTRUC = 16,
  parameter int NB_OPCODE  = 5,
  parameter int NB_ADDR    = 11,
  parameter int RAM_DEPTH  = 2048,
  parameter int NB_CYCLES  = 16,
  parameter logic [NB_OPCODE-1:0] HLT_OPCODE =
    program_memory_pkg::HLT_OPCODE
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load_valid,
  input  logic [NB_INSTRUC-1:0] i_load_data,
  input  logic                  i_load_last,
  output logic                  o_load_ready,
  input  logic                  i_start,
  input  logic [NB_ADDR-1:0]    i_addr,
  output logic [NB_INSTRUC-1:0] o_instruc,
  output logic                  o_cpu_enable,
  output logic                  o_halt,
  output logic [NB_ADDR:0]      o_prog_len,
  output logic [NB_CYCLES-1:0]  o_cycle_count,
  output logic                  o_error
);

  import program_memory_pkg::*;

  state_t             state;
  state_t             state_next;
  logic [NB_ADDR-1:0] wr_ptr;
  logic [NB_ADDR-1:0] ram_addr;
  logic               fetch_valid;
  logic               fetch_en;
  logic               accept;
  logic               full;
  logic               start_run;
  logic               hlt_seen;

  assign accept    = i_load_valid && o_load_ready;
  assign full      = wr_ptr == NB_ADDR'(RAM_DEPTH-1);
  assign fetch_en  = state == RUN;
  assign start_run = i_start &&
                     (state == READY || state == HALT);
  assign ram_addr  = fetch_en ? i_addr : wr_ptr;

  // fetch_valid hides the stale word seen in the first RUN cycle.
  assign hlt_seen = fetch_en && fetch_valid &&
    o_instruc[NB_INSTRUC-1 -: NB_OPCODE] == HLT_OPCODE;

  always_ff @(posedge i_clk) begin
    if (i_rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, LOAD:
        if (accept)
          state_next = (i_load_last || full) ? READY : LOAD;
      READY, HALT:
        if (i_start)
          state_next = RUN;
      RUN:
        if (hlt_seen)
          state_next = HALT;
      default:
        state_next = IDLE;
    endcase
  end

  always_comb begin
    o_load_ready = 1'b0;
    o_cpu_enable = 1'b0;
    o_halt       = 1'b0;
    unique case (state)
      IDLE, LOAD: o_load_ready = 1'b1;
      RUN:        o_cpu_enable = 1'b1;
      HALT:       o_halt       = 1'b1;
      default:    ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr        <= '0;
      o_prog_len    <= '0;
      o_error       <= 1'b0;
      o_cycle_count <= '0;
      fetch_valid   <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr     <= wr_ptr + NB_ADDR'(1);
        o_prog_len <= o_prog_len + (NB_ADDR+1)'(1);
        if (full && !i_load_last)
          o_error <= 1'b1;
      end
      if (start_run) begin
        o_cycle_count <= '0;
        fetch_valid   <= 1'b0;
      end else if (fetch_en) begin
        fetch_valid <= 1'b1;
        if (o_cycle_count != {NB_CYCLES{1'b1}})
          o_cycle_count <= o_cycle_count + NB_CYCLES'(1);
      end
    end
  end

  prog_ram #(
    .NB_DATA (NB_INSTRUC),
    .NB_ADDR (NB_ADDR),
    .DEPTH   (RAM_DEPTH)
  ) u_ram (
    .clk   (i_clk),
    .rst   (i_rst),
    .we    (accept),
    .re    (fetch_en),
    .addr  (ram_addr),
    .wdata (i_load_data),
    .rdata (o_instruc)
  );

endmodule

// File: tb/tb_program_memory.sv
// Directed bench for program_memory: default, small-RAM
// and narrow-counter instances share one stimulus bus.
module tb_program_memory;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic [15:0] load_data = '0;
  logic        load_last = 1'b0;
  logic        start = 1'b0;
  logic [10:0] addr = '0;

  logic        a_ready, a_en, a_halt, a_err;
  logic [15:0] a_ins;
  logic [11:0] a_len;
  logic [15:0] a_cnt;

  logic        b_ready, b_en, b_halt, b_err;
  logic [15:0] b_ins;
  logic [11:0] b_len;
  logic [15:0] b_cnt;

  logic        c_ready, c_en, c_halt, c_err;
  logic [15:0] c_ins;
  logic [11:0] c_len;
  logic [3:0]  c_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] sb[$];
  logic [10:0] addr_l[$];
  logic [15:0] exp_l[$];

  always #5 clk = ~clk;

  program_memory dut_a (
    .i_clk(clk), .i_rst(rst),
    .i_load_valid(load_valid), .i_load_data(load_data),
    .i_load_last(load_last), .o_load_ready(a_ready),
    .i_start(start), .i_addr(addr), .o_instruc(a_ins),
    .o_cpu_enable(a_en), .o_halt(a_halt),
    .o_prog_len(a_len), .o_cycle_count(a_cnt),
    .o_error(a_err)
  );

  program_memory #(.RAM_DEPTH(4)) dut_b (
    .i_clk(clk), .i_rst(rst),
    .i_load_valid(load_valid), .i_load_data(load_data),
    .i_load_last(load_last), .o_load_ready(b_ready),
    .i_start(start), .i_addr(addr), .o_instruc(b_ins),
    .o_cpu_enable(b_en), .o_halt(b_halt),
    .o_prog_len(b_len), .o_cycle_count(b_cnt),
    .o_error(b_err)
  );

  program_memory #(.NB_CYCLES(4)) dut_c (
    .i_clk(clk), .i_rst(rst),
    .i_load_valid(load_valid), .i_load_data(load_data),
    .i_load_last(load_last), .o_load_ready(c_ready),
    .i_start(start), .i_addr(addr), .o_instruc(c_ins),
    .o_cpu_enable(c_en), .o_halt(c_halt),
    .o_prog_len(c_len), .o_cycle_count(c_cnt),
    .o_error(c_err)
  );

  function automatic logic [31:0] obs_ins(input int sel);
    return sel == 0 ? a_ins : sel == 1 ? b_ins : c_ins;
  endfunction

  function automatic logic [31:0] obs_en(input int sel);
    return sel == 0 ? a_en : sel == 1 ? b_en : c_en;
  endfunction

  function automatic logic [31:0] obs_halt(input int sel);
    return sel == 0 ? a_halt : sel == 1 ? b_halt : c_halt;
  endfunction

  function automatic logic [31:0] obs_cnt(input int sel);
    return sel == 0 ? 32'(a_cnt) :
           sel == 1 ? 32'(b_cnt) : 32'(c_cnt);
  endfunction

  function automatic logic [31:0] sat(
    input int v, input logic [31:0] maxc
  );
    return 32'(v) > maxc ? maxc : 32'(v);
  endfunction

  task automatic chk(
    input string tag,
    input logic [31:0] obs,
    input logic [31:0] expv
  );
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    load_valid = 1'b0;
    load_last = 1'b0;
    start = 1'b0;
    addr = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_ins"},   a_ins,   0);
    chk({tag, "_en"},    a_en,    0);
    chk({tag, "_halt"},  a_halt,  0);
    chk({tag, "_len"},   a_len,   0);
    chk({tag, "_cnt"},   a_cnt,   0);
    chk({tag, "_err"},   a_err,   0);
    chk({tag, "_ready"}, a_ready, 1);
  endtask

  task automatic send(
    input logic [15:0] d,
    input logic l,
    input bit rnd,
    input logic s
  );
    int tries = 0;
    do begin
      @(negedge clk);
      tries++;
      load_valid = (rnd && tries < 8) ?
                   1'($urandom_range(0, 1)) : 1'b1;
      load_data = d;
      load_last = l;
      start = s;
    end while (!load_valid);
  endtask

  task automatic idle_bus();
    @(negedge clk);
    load_valid = 1'b0;
    load_last = 1'b0;
    start = 1'b0;
  endtask

  task automatic set_prog(
    input logic [15:0] w0, input logic [15:0] w1,
    input logic [15:0] w2, input int n
  );
    logic [15:0] w[3];
    w[0] = w0; w[1] = w1; w[2] = w2;
    addr_l.delete();
    exp_l.delete();
    for (int i = 0; i < n; i++) begin
      addr_l.push_back(11'(i));
      exp_l.push_back(w[i]);
    end
  endtask

  // Last address of each program must fetch HLT.
  task automatic run_prog(input int sel);
    logic [31:0] maxc;
    int n;
    maxc = (sel == 2) ? 32'd15 : 32'hffff;
    n = addr_l.size();
    sb.delete();
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 0) begin
        chk("run_halt_clr", obs_halt(sel), 0);
        chk("run_en", obs_en(sel), 1);
      end
      chk("run_cnt", obs_cnt(sel), sat(i, maxc));
      if (sb.size() > 0)
        chk("fetch", obs_ins(sel), 32'(sb.pop_front()));
      addr = addr_l[i];
      sb.push_back(exp_l[i]);
    end
    @(negedge clk);
    chk("fetch_last", obs_ins(sel), 32'(sb.pop_front()));
    chk("en_pre_halt", obs_en(sel), 1);
    @(negedge clk);
    chk("halt", obs_halt(sel), 1);
    chk("halt_en", obs_en(sel), 0);
    chk("halt_cnt", obs_cnt(sel), sat(n + 1, maxc));
  endtask

  initial begin
    do_reset();
    chk_reset_a("rst");

    send(16'h0801, 1'b0, 1'b0, 1'b0);
    send(16'h1802, 1'b0, 1'b0, 1'b0);
    send(16'h0000, 1'b1, 1'b0, 1'b0);
    idle_bus();
    chk("ld3_len", a_len, 3);
    chk("ld3_ready", a_ready, 0);
    chk("ld3_en", a_en, 0);
    set_prog(16'h0801, 16'h1802, 16'h0000, 3);
    run_prog(0);

    send(16'h1234, 1'b1, 1'b0, 1'b0);
    idle_bus();
    chk("halt_noload_len", a_len, 3);
    chk("halt_ready", a_ready, 0);
    run_prog(0);

    do_reset();
    send(16'h0801, 1'b0, 1'b1, 1'b0);
    send(16'h1802, 1'b0, 1'b1, 1'b1);
    send(16'h2803, 1'b0, 1'b1, 1'b0);
    chk("bp_mid_len", a_len, 2);
    chk("bp_mid_ready", a_ready, 1);
    chk("bp_start_ign", a_en, 0);
    send(16'h3804, 1'b0, 1'b1, 1'b0);
    chk("bp_not_ready", a_ready, 1);
    send(16'h0000, 1'b1, 1'b1, 1'b0);
    idle_bus();
    chk("bp_len", a_len, 5);
    chk("bp_ready", a_ready, 0);
    chk("bp_en", a_en, 0);
    addr_l.delete();
    exp_l.delete();
    for (int i = 0; i < 5; i++) begin
      addr_l.push_back(11'(i));
      exp_l.push_back(i == 4 ? 16'h0000 :
                      16'h0801 + 16'(i) * 16'h1001);
    end
    run_prog(0);

    do_reset();
    for (int i = 0; i < 4; i++)
      send(16'h0811 + 16'(i), 1'b0, 1'b0, 1'b0);
    chk("ovf_err_early", b_err, 0);
    send(16'h0815, 1'b0, 1'b0, 1'b0);
    chk("ovf_err", b_err, 1);
    chk("ovf_ready", b_ready, 0);
    chk("ovf_len4", b_len, 4);
    send(16'h0816, 1'b0, 1'b0, 1'b0);
    idle_bus();
    chk("ovf_len", b_len, 4);
    chk("ovf_err_hold", b_err, 1);
    chk("ovf_en", b_en, 0);
    addr_l.delete();
    exp_l.delete();
    addr_l.push_back(11'd1);
    exp_l.push_back(16'h0812);
    addr_l.push_back(11'd5);
    exp_l.push_back(16'h0000);
    run_prog(1);
    chk("ovf_err_run", b_err, 1);

    do_reset();
    send(16'h0801, 1'b0, 1'b0, 1'b0);
    send(16'h1802, 1'b0, 1'b0, 1'b0);
    send(16'h0000, 1'b1, 1'b0, 1'b0);
    idle_bus();
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      addr = 11'(i);
    end
    chk("mid_en", a_en, 1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_a("midrst");
    rst = 1'b0;
    send(16'h1805, 1'b0, 1'b0, 1'b0);
    send(16'h0000, 1'b1, 1'b0, 1'b0);
    idle_bus();
    chk("reload_len", a_len, 2);
    set_prog(16'h1805, 16'h0000, 16'h0000, 2);
    run_prog(0);

    do_reset();
    addr_l.delete();
    exp_l.delete();
    for (int i = 0; i < 21; i++) begin
      logic [15:0] w;
      w = (i == 20) ? 16'h0000 : 16'h0800 + 16'(i);
      send(w, 1'(i == 20), 1'b0, 1'b0);
      addr_l.push_back(11'(i));
      exp_l.push_back(w);
    end
    idle_bus();
    chk("sat_len", c_len, 21);
    run_prog(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
